// File: rtl/wb_posted_write_buffer.sv
// Posted-write buffer between a Wishbone CPU master and the interconnect.
// Writes are queued and acked early; reads wait for the queue to drain.
module wb_posted_write_buffer #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_n_i,
    input  logic [AW-1:0]     wbs_adr_i,
    input  logic [DW-1:0]     wbs_dat_i,
    input  logic [DW/8-1:0]   wbs_sel_i,
    input  logic              wbs_we_i,
    input  logic              wbs_cyc_i,
    input  logic              wbs_stb_i,
    output logic [DW-1:0]     wbs_dat_o,
    output logic              wbs_ack_o,
    output logic              wbs_err_o,
    output logic [AW-1:0]     wbm_adr_o,
    output logic [DW-1:0]     wbm_dat_o,
    output logic [DW/8-1:0]   wbm_sel_o,
    output logic              wbm_we_o,
    output logic              wbm_cyc_o,
    output logic              wbm_stb_o,
    output logic [2:0]        wbm_cti_o,
    output logic [1:0]        wbm_bte_o,
    input  logic [DW-1:0]     wbm_dat_i,
    input  logic              wbm_ack_i,
    input  logic              wbm_err_i,
    output logic              idle_o,
    output logic              wr_err_o,
    output logic [AW-1:0]     wr_err_adr_o,
    input  logic              wr_err_clr_i
);

    localparam int SW    = DW / 8;
    localparam int DEPTH = 1 << DEPTH_LOG2;

    localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ZERO = (DEPTH_LOG2 + 1)'(0);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ZERO = DEPTH_LOG2'(0);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_READ  = 2'd2;

    logic [AW-1:0]         fifo_adr_r [DEPTH];
    logic [DW-1:0]         fifo_dat_r [DEPTH];
    logic [SW-1:0]         fifo_sel_r [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_r;
    logic [DEPTH_LOG2-1:0] rd_ptr_r;
    logic [DEPTH_LOG2:0]   count_r;
    logic [1:0]            state_r;
    logic                  wr_ack_r;

    logic full_s;
    logic empty_s;
    logic wr_req_s;
    logic rd_req_s;
    logic push_s;
    logic pop_s;
    logic rd_live_s;
    logic wr_err_set_s;

    assign full_s       = (count_r == CNT_FULL);
    assign empty_s      = (count_r == CNT_ZERO);
    assign wr_req_s     = wbs_cyc_i & wbs_stb_i & wbs_we_i;
    assign rd_req_s     = wbs_cyc_i & wbs_stb_i & ~wbs_we_i;
    // Fullness uses the pre-pop count: a push never relies on a same-cycle pop.
    assign push_s       = wr_req_s & ~full_s & ~wr_ack_r;
    assign pop_s        = (state_r == ST_WRITE) & (wbm_ack_i | wbm_err_i);
    // A read response is only forwarded while the CPU is still asking for it.
    assign rd_live_s    = (state_r == ST_READ) & rd_req_s;
    assign wr_err_set_s = pop_s & wbm_err_i;

    assign idle_o    = empty_s & (state_r == ST_IDLE);
    assign wbm_cti_o = 3'b000;
    assign wbm_bte_o = 2'b00;

    // CPU-side response mux: early write ack, or read pass-through.
    always_comb begin
        wbs_ack_o = wr_ack_r;
        wbs_err_o = 1'b0;
        wbs_dat_o = {DW{1'b0}};
        if (rd_live_s) begin
            wbs_ack_o = wr_ack_r | wbm_ack_i;
            wbs_err_o = wbm_err_i;
            wbs_dat_o = wbm_dat_i;
        end else begin
            wbs_ack_o = wr_ack_r;
            wbs_err_o = 1'b0;
            wbs_dat_o = {DW{1'b0}};
        end
    end

    // FIFO storage; contents need no reset since pointers gate validity.
    always_ff @(posedge wb_clk_i) begin
        if (push_s) begin
            fifo_adr_r[wr_ptr_r] <= wbs_adr_i;
            fifo_dat_r[wr_ptr_r] <= wbs_dat_i;
            fifo_sel_r[wr_ptr_r] <= wbs_sel_i;
        end
    end

    // FIFO pointers, occupancy and early write ack.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            count_r  <= CNT_ZERO;
            wr_ack_r <= 1'b0;
        end else begin
            wr_ack_r <= push_s;
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Master-side FSM; one idle cycle always separates transactions.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_r   <= ST_IDLE;
            wbm_adr_o <= {AW{1'b0}};
            wbm_dat_o <= {DW{1'b0}};
            wbm_sel_o <= {SW{1'b0}};
            wbm_we_o  <= 1'b0;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (!empty_s) begin
                        wbm_adr_o <= fifo_adr_r[rd_ptr_r];
                        wbm_dat_o <= fifo_dat_r[rd_ptr_r];
                        wbm_sel_o <= fifo_sel_r[rd_ptr_r];
                        wbm_we_o  <= 1'b1;
                        wbm_cyc_o <= 1'b1;
                        wbm_stb_o <= 1'b1;
                        state_r   <= ST_WRITE;
                    end else if (rd_req_s) begin
                        wbm_adr_o <= wbs_adr_i;
                        wbm_dat_o <= {DW{1'b0}};
                        wbm_sel_o <= wbs_sel_i;
                        wbm_we_o  <= 1'b0;
                        wbm_cyc_o <= 1'b1;
                        wbm_stb_o <= 1'b1;
                        state_r   <= ST_READ;
                    end else begin
                        state_r   <= ST_IDLE;
                    end
                end
                ST_WRITE, ST_READ: begin
                    if (wbm_ack_i || wbm_err_i) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        state_r   <= ST_IDLE;
                    end else begin
                        state_r   <= state_r;
                    end
                end
                default: begin
                    wbm_cyc_o <= 1'b0;
                    wbm_stb_o <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

    // Sticky posted-write error; only the first failing address is kept.
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            wr_err_o     <= 1'b0;
            wr_err_adr_o <= {AW{1'b0}};
        end else if (wr_err_set_s) begin
            wr_err_o <= 1'b1;
            if (!wr_err_o) begin
                wr_err_adr_o <= wbm_adr_o;
            end
        end else if (wr_err_clr_i) begin
            wr_err_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_posted_write_buffer.sv
// Directed self-checking bench for wb_posted_write_buffer.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_wb_posted_write_buffer;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_n_i;
    logic [31:0] wbs_adr_i, wbs_dat_i, wbs_dat_o;
    logic [3:0]  wbs_sel_i;
    logic        wbs_we_i, wbs_cyc_i, wbs_stb_i, wbs_ack_o, wbs_err_o;
    logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
    logic [3:0]  wbm_sel_o;
    logic        wbm_we_o, wbm_cyc_o, wbm_stb_o, wbm_ack_i, wbm_err_i;
    logic [2:0]  wbm_cti_o;
    logic [1:0]  wbm_bte_o;
    logic        idle_o, wr_err_o, wr_err_clr_i;
    logic [31:0] wr_err_adr_o;

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [31:0] exp_adr [5] = '{32'h1000_0000, 32'h1000_0004, 32'h1000_0008, 32'h1000_000C, 32'h1000_0010};
    logic [31:0] exp_dat [5] = '{32'hA5A5_0000, 32'hA5A5_0001, 32'hA5A5_0002, 32'hA5A5_0003, 32'hA5A5_0004};
    logic [3:0]  exp_sel [5] = '{4'hF, 4'h1, 4'h2, 4'hC, 4'h8};

    wb_posted_write_buffer dut (
        .wb_clk_i(wb_clk_i), .wb_rst_n_i(wb_rst_n_i),
        .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i), .wbs_sel_i(wbs_sel_i),
        .wbs_we_i(wbs_we_i), .wbs_cyc_i(wbs_cyc_i), .wbs_stb_i(wbs_stb_i),
        .wbs_dat_o(wbs_dat_o), .wbs_ack_o(wbs_ack_o), .wbs_err_o(wbs_err_o),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
        .wbm_we_o(wbm_we_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
        .wbm_cti_o(wbm_cti_o), .wbm_bte_o(wbm_bte_o),
        .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i),
        .idle_o(idle_o), .wr_err_o(wr_err_o), .wr_err_adr_o(wr_err_adr_o),
        .wr_err_clr_i(wr_err_clr_i)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    task automatic cpu_drop();
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0; wbs_we_i = 1'b0;
    endtask

    // Presents a write and waits (bounded) for its ack; leaves the request asserted.
    task automatic post_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                              input int budget, output int waited);
        wbs_adr_i = a; wbs_dat_i = d; wbs_sel_i = s;
        wbs_we_i = 1'b1; wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
        waited = 0;
        do begin
            @(negedge wb_clk_i);
            waited++;
        end while (!wbs_ack_o && waited < budget);
    endtask

    // Slave model: accepts n writes from exp_* starting at idx, acking after lat cycles.
    task automatic slave_drain(input int idx, input int n, input int lat);
        for (int k = idx; k < idx + n; k++) begin
            int w = 0;
            while (!(wbm_cyc_o && wbm_stb_o) && w < 20) begin
                @(negedge wb_clk_i);
                w++;
            end
            total_cnt++;
            if (!(wbm_cyc_o && wbm_stb_o)) $display("FAIL drain_timeout_%0d got cyc=%0b exp 1", k, wbm_cyc_o);
            else pass_cnt++;
            total_cnt++;
            if ({wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o} !== {1'b1, exp_adr[k], exp_dat[k], exp_sel[k]})
                $display("FAIL drain_order_%0d got we=%0b adr=%h dat=%h sel=%h exp adr=%h dat=%h sel=%h",
                         k, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o, exp_adr[k], exp_dat[k], exp_sel[k]);
            else pass_cnt++;
            repeat (lat) @(negedge wb_clk_i);
            wbm_ack_i = 1'b1;
            @(negedge wb_clk_i);
            wbm_ack_i = 1'b0;
        end
    endtask

    task automatic test_reset();
        @(negedge wb_clk_i);
        total_cnt++;
        if ({wbs_ack_o, wbs_err_o, wbs_dat_o, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o,
             wr_err_o, wr_err_adr_o, idle_o, wbm_cti_o, wbm_bte_o} !== {102'd0, 1'b1, 5'd0})
            $display("FAIL reset_outputs got ack=%0b cyc=%0b adr=%h err=%0b idle=%0b cti=%0d exp zeros idle=1",
                     wbs_ack_o, wbm_cyc_o, wbm_adr_o, wr_err_o, idle_o, wbm_cti_o);
        else pass_cnt++;
        wb_rst_n_i = 1'b1;
        @(negedge wb_clk_i);
    endtask

    task automatic test_single_write();
        int w;
        bit hold_ok = 1'b1;
        total_cnt++;
        wbs_adr_i = 32'h9000_0000; wbs_dat_i = 32'hDEAD_BEEF; wbs_sel_i = 4'hF;
        wbs_we_i = 1'b1; wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
        #1;
        if (wbs_ack_o !== 1'b0) $display("FAIL sw_no_early_ack got %0b exp 0", wbs_ack_o);
        else pass_cnt++;
        @(negedge wb_clk_i);
        total_cnt++;
        if (wbs_ack_o !== 1'b1) $display("FAIL sw_ack_latency got %0b exp 1", wbs_ack_o);
        else pass_cnt++;
        total_cnt++;
        if ({wbm_cyc_o, idle_o} !== 2'b00) $display("FAIL sw_pre_bus got cyc=%0b idle=%0b exp 0 0", wbm_cyc_o, idle_o);
        else pass_cnt++;
        cpu_drop();
        @(negedge wb_clk_i);
        total_cnt++;
        if ({wbs_ack_o, wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o} !== {4'b0111, 32'h9000_0000, 32'hDEAD_BEEF, 4'hF})
            $display("FAIL sw_bus_write got ack=%0b cyc=%0b we=%0b adr=%h dat=%h sel=%h exp 0 1 1 90000000 deadbeef f",
                     wbs_ack_o, wbm_cyc_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o);
        else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            @(negedge wb_clk_i);
            if (!(wbm_cyc_o && wbm_stb_o && wbm_adr_o == 32'h9000_0000)) hold_ok = 1'b0;
        end
        total_cnt++;
        if (hold_ok !== 1'b1) $display("FAIL sw_hold_5 got %0b exp 1", hold_ok);
        else pass_cnt++;
        wbm_ack_i = 1'b1;
        @(negedge wb_clk_i);
        wbm_ack_i = 1'b0;
        total_cnt++;
        if ({wbm_cyc_o, idle_o} !== 2'b01) $display("FAIL sw_idle_after got cyc=%0b idle=%0b exp 0 1", wbm_cyc_o, idle_o);
        else pass_cnt++;
        w = 0;
    endtask

    task automatic test_back_to_back();
        int w;
        for (int i = 0; i < 4; i++) begin
            post_write(exp_adr[i], exp_dat[i], exp_sel[i], 6, w);
            total_cnt++;
            if (w !== ((i == 0) ? 1 : 2)) $display("FAIL b2b_ack_spacing_%0d got %0d exp %0d", i, w, (i == 0) ? 1 : 2);
            else pass_cnt++;
        end
        post_write(exp_adr[4], exp_dat[4], exp_sel[4], 6, w);
        total_cnt++;
        if (wbs_ack_o !== 1'b0) $display("FAIL b2b_full_stall got ack=%0b exp 0", wbs_ack_o);
        else pass_cnt++;
        total_cnt++;
        if ({wbm_cyc_o, wbm_adr_o, wbm_dat_o} !== {1'b1, exp_adr[0], exp_dat[0]})
            $display("FAIL b2b_first_on_bus got cyc=%0b adr=%h dat=%h exp 1 %h %h", wbm_cyc_o, wbm_adr_o, wbm_dat_o, exp_adr[0], exp_dat[0]);
        else pass_cnt++;
        wbm_ack_i = 1'b1;
        @(negedge wb_clk_i);
        wbm_ack_i = 1'b0;
        total_cnt++;
        if (wbs_ack_o !== 1'b0) $display("FAIL b2b_prepop_full got ack=%0b exp 0", wbs_ack_o);
        else pass_cnt++;
        @(negedge wb_clk_i);
        total_cnt++;
        if (wbs_ack_o !== 1'b1) $display("FAIL b2b_fifth_ack got ack=%0b exp 1", wbs_ack_o);
        else pass_cnt++;
        cpu_drop();
        slave_drain(1, 4, 1);
        @(negedge wb_clk_i);
        total_cnt++;
        if (idle_o !== 1'b1) $display("FAIL b2b_idle got %0b exp 1", idle_o);
        else pass_cnt++;
    endtask

    task automatic test_read_after_write();
        int w;
        post_write(32'h5000_0010, 32'h0000_1234, 4'hF, 4, w);
        wbs_we_i = 1'b0;
        @(negedge wb_clk_i);
        total_cnt++;
        if ({wbm_cyc_o, wbm_we_o} !== 2'b11) $display("FAIL raw_write_first got cyc=%0b we=%0b exp 1 1", wbm_cyc_o, wbm_we_o);
        else pass_cnt++;
        repeat (2) @(negedge wb_clk_i);
        total_cnt++;
        if ({wbm_we_o, wbs_ack_o} !== 2'b10) $display("FAIL raw_read_held got we=%0b ack=%0b exp 1 0", wbm_we_o, wbs_ack_o);
        else pass_cnt++;
        wbm_ack_i = 1'b1;
        @(negedge wb_clk_i);
        wbm_ack_i = 1'b0;
        total_cnt++;
        if ({wbm_cyc_o, wbs_ack_o} !== 2'b00) $display("FAIL raw_gap got cyc=%0b ack=%0b exp 0 0", wbm_cyc_o, wbs_ack_o);
        else pass_cnt++;
        @(negedge wb_clk_i);
        total_cnt++;
        if ({wbm_cyc_o, wbm_we_o, wbm_adr_o} !== {2'b10, 32'h5000_0010})
            $display("FAIL raw_read_issue got cyc=%0b we=%0b adr=%h exp 1 0 50000010", wbm_cyc_o, wbm_we_o, wbm_adr_o);
        else pass_cnt++;
        wbm_dat_i = 32'h0000_1234; wbm_ack_i = 1'b1;
        #1;
        total_cnt++;
        if ({wbs_ack_o, wbs_dat_o} !== {1'b1, 32'h0000_1234}) $display("FAIL raw_read_data got ack=%0b dat=%h exp 1 00001234", wbs_ack_o, wbs_dat_o);
        else pass_cnt++;
        @(negedge wb_clk_i);
        wbm_ack_i = 1'b0; wbm_dat_i = 32'h0; cpu_drop();
        #1;
        total_cnt++;
        if ({wbs_ack_o, wbs_dat_o, wbm_cyc_o} !== 34'd0) $display("FAIL raw_done got ack=%0b dat=%h cyc=%0b exp 0", wbs_ack_o, wbs_dat_o, wbm_cyc_o);
        else pass_cnt++;
    endtask

    task automatic test_write_error();
        int w;
        post_write(32'h2000_0004, 32'h1111_1111, 4'hF, 4, w);
        post_write(32'h2000_0008, 32'h2222_2222, 4'hF, 4, w);
        cpu_drop();
        total_cnt++;
        if (wbm_adr_o !== 32'h2000_0004) $display("FAIL werr_first_adr got %h exp 20000004", wbm_adr_o);
        else pass_cnt++;
        wbm_err_i = 1'b1;
        #1;
        total_cnt++;
        if (wbs_err_o !== 1'b0) $display("FAIL werr_not_on_cpu got %0b exp 0", wbs_err_o);
        else pass_cnt++;
        @(negedge wb_clk_i);
        wbm_err_i = 1'b0;
        total_cnt++;
        if ({wr_err_o, wr_err_adr_o} !== {1'b1, 32'h2000_0004}) $display("FAIL werr_capture got flag=%0b adr=%h exp 1 20000004", wr_err_o, wr_err_adr_o);
        else pass_cnt++;
        @(negedge wb_clk_i);
        total_cnt++;
        if ({wbm_cyc_o, wbm_adr_o, wbm_dat_o} !== {1'b1, 32'h2000_0008, 32'h2222_2222})
            $display("FAIL werr_second_issue got cyc=%0b adr=%h dat=%h exp 1 20000008 22222222", wbm_cyc_o, wbm_adr_o, wbm_dat_o);
        else pass_cnt++;
        wbm_ack_i = 1'b1;
        @(negedge wb_clk_i);
        wbm_ack_i = 1'b0;
        total_cnt++;
        if (idle_o !== 1'b1) $display("FAIL werr_second_done got idle=%0b exp 1", idle_o);
        else pass_cnt++;
        // A later error while the flag is set must keep the first address.
        post_write(32'h2000_000C, 32'h3333_3333, 4'hF, 4, w);
        cpu_drop();
        @(negedge wb_clk_i);
        wbm_err_i = 1'b1;
        @(negedge wb_clk_i);
        wbm_err_i = 1'b0;
        total_cnt++;
        if ({wr_err_o, wr_err_adr_o} !== {1'b1, 32'h2000_0004}) $display("FAIL werr_no_overwrite got flag=%0b adr=%h exp 1 20000004", wr_err_o, wr_err_adr_o);
        else pass_cnt++;
        wr_err_clr_i = 1'b1;
        @(negedge wb_clk_i);
        wr_err_clr_i = 1'b0;
        total_cnt++;
        if ({wr_err_o, wr_err_adr_o} !== {1'b0, 32'h2000_0004}) $display("FAIL werr_clear got flag=%0b adr=%h exp 0 20000004", wr_err_o, wr_err_adr_o);
        else pass_cnt++;
        post_write(32'h2000_0010, 32'h4444_4444, 4'hF, 4, w);
        cpu_drop();
        @(negedge wb_clk_i);
        wbm_err_i = 1'b1; wr_err_clr_i = 1'b1;
        @(negedge wb_clk_i);
        wbm_err_i = 1'b0; wr_err_clr_i = 1'b0;
        total_cnt++;
        if (wr_err_o !== 1'b1) $display("FAIL werr_set_wins got %0b exp 1", wr_err_o);
        else pass_cnt++;
        wr_err_clr_i = 1'b1;
        @(negedge wb_clk_i);
        wr_err_clr_i = 1'b0;
        @(negedge wb_clk_i);
    endtask

    task automatic test_read_error();
        wbs_adr_i = 32'h3000_0000; wbs_sel_i = 4'hF;
        wbs_we_i = 1'b0; wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1;
        @(negedge wb_clk_i);
        total_cnt++;
        if ({wbm_cyc_o, wbm_we_o, wbm_adr_o} !== {2'b10, 32'h3000_0000}) $display("FAIL rerr_issue got cyc=%0b we=%0b adr=%h exp 1 0 30000000", wbm_cyc_o, wbm_we_o, wbm_adr_o);
        else pass_cnt++;
        wbm_err_i = 1'b1;
        #1;
        total_cnt++;
        if ({wbs_err_o, wbs_ack_o} !== 2'b10) $display("FAIL rerr_resp got err=%0b ack=%0b exp 1 0", wbs_err_o, wbs_ack_o);
        else pass_cnt++;
        @(negedge wb_clk_i);
        wbm_err_i = 1'b0; cpu_drop();
        #1;
        total_cnt++;
        if ({wbs_err_o, wr_err_o, wbm_cyc_o} !== 3'b000) $display("FAIL rerr_after got err=%0b wr_err=%0b cyc=%0b exp 0 0 0", wbs_err_o, wr_err_o, wbm_cyc_o);
        else pass_cnt++;
        @(negedge wb_clk_i);
    endtask

    task automatic test_reset_mid_write();
        int w;
        int seen = 0;
        for (int i = 0; i < 3; i++) post_write(32'h4000_0000 + 32'(i * 4), 32'h7700_0000 + 32'(i), 4'hF, 4, w);
        cpu_drop();
        total_cnt++;
        if ({wbm_cyc_o, wbm_adr_o} !== {1'b1, 32'h4000_0000}) $display("FAIL rst_pre_write got cyc=%0b adr=%h exp 1 40000000", wbm_cyc_o, wbm_adr_o);
        else pass_cnt++;
        #2 wb_rst_n_i = 1'b0;
        #1;
        total_cnt++;
        if ({wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbm_sel_o, wbs_ack_o, idle_o} !== {71'd0, 1'b1})
            $display("FAIL rst_async got cyc=%0b we=%0b adr=%h dat=%h ack=%0b idle=%0b exp zeros idle=1",
                     wbm_cyc_o, wbm_we_o, wbm_adr_o, wbm_dat_o, wbs_ack_o, idle_o);
        else pass_cnt++;
        repeat (2) @(negedge wb_clk_i);
        wb_rst_n_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge wb_clk_i);
            if (wbm_cyc_o) seen++;
        end
        total_cnt++;
        if ({seen, idle_o} !== {32'd0, 1'b1}) $display("FAIL rst_discard got bus_cycles=%0d idle=%0b exp 0 1", seen, idle_o);
        else pass_cnt++;
    endtask

    initial begin
        wb_rst_n_i = 1'b0; wr_err_clr_i = 1'b0;
        wbs_adr_i = 32'h0; wbs_dat_i = 32'h0; wbs_sel_i = 4'h0;
        wbs_we_i = 1'b0; wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        wbm_dat_i = 32'h0; wbm_ack_i = 1'b0; wbm_err_i = 1'b0;
        test_reset();
        test_single_write();
        test_back_to_back();
        test_read_after_write();
        test_write_error();
        test_read_error();
        test_reset_mid_write();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/wb_posted_write_buffer.md
Name: wb_posted_write_buffer

Overview:
- Sits between the picorv32_wb Wishbone master and the SoC interconnect master port.
- Posts CPU writes into a small FIFO and acks them early, so stores to slow targets (SDRAM, UART, GPIO) do not stall the core.
- Reads wait until all posted writes have drained, then pass through. This keeps read-after-write ordering intact.
- Bus errors on posted writes are reported through a sticky flag and a captured address.

Parameters:
- AW, 32, address width.
- DW, 32, data width; SEL width is DW/8.
- DEPTH_LOG2, 2, FIFO depth is 2**DEPTH_LOG2 entries (default 4).

Ports:
- wb_clk_i  in  1  clock; all logic on rising edge.
- wb_rst_n_i  in  1  asynchronous, active-low reset.
- wbs_adr_i  in  AW  CPU-side address.
- wbs_dat_i  in  DW  CPU write data.
- wbs_sel_i  in  DW/8  byte selects.
- wbs_we_i  in  1  write enable.
- wbs_cyc_i  in  1  cycle.
- wbs_stb_i  in  1  strobe.
- wbs_dat_o  out  DW  read data.
- wbs_ack_o  out  1  acknowledge.
- wbs_err_o  out  1  read error.
- wbm_adr_o  out  AW  interconnect-side address.
- wbm_dat_o  out  DW  write data.
- wbm_sel_o  out  DW/8  byte selects.
- wbm_we_o  out  1  write enable.
- wbm_cyc_o  out  1  cycle.
- wbm_stb_o  out  1  strobe.
- wbm_cti_o  out  3  constant 3'b000 (classic).
- wbm_bte_o  out  2  constant 2'b00.
- wbm_dat_i  in  DW  read data.
- wbm_ack_i  in  1  acknowledge.
- wbm_err_i  in  1  error.
- idle_o  out  1  FIFO empty and master FSM in IDLE (for fence and reset sequencing).
- wr_err_o  out  1  sticky posted-write error.
- wr_err_adr_o  out  AW  address of the first failing posted write.
- wr_err_clr_i  in  1  clears wr_err_o.

Behaviour:
- Reset (wb_rst_n_i low, asynchronous):
  - FIFO pointers and count cleared; queued writes are discarded.
  - FSM goes to IDLE.
  - All wbs_*/wbm_* outputs, wr_err_o and wr_err_adr_o go to 0; idle_o=1.
- Write accept:
  - Condition: wbs_cyc_i&wbs_stb_i&wbs_we_i, FIFO not full, and wbs_ack_o currently 0.
  - Action: push {adr,dat,sel} and register wbs_ack_o=1 for exactly one cycle, i.e. ack in the cycle after the request is seen.
  - FIFO full: no ack; the request stalls until an entry frees.
  - Fullness is evaluated on the pre-pop count, so a push into a full FIFO is not taken even if a pop happens that cycle.
  - Push and pop in the same cycle leave the count unchanged. Pointers wrap modulo depth.
- Read request:
  - Condition: wbs_cyc_i&wbs_stb_i&~wbs_we_i.
  - Serviced only when the FIFO is empty and the FSM is in IDLE.
  - During READ, wbs_ack_o=wbm_ack_i, wbs_err_o=wbm_err_i, wbs_dat_o=wbm_dat_i (combinational pass-through). Otherwise wbs_dat_o=0 and wbs_err_o=0.
- Master FSM states (registered wbm_* outputs):
  - IDLE:
    - If FIFO not empty: load head into wbm_adr/dat/sel, set we=1, cyc=stb=1, go to WRITE.
    - Else if a read request is pending: load wbs_adr_i and wbs_sel_i, set we=0, cyc=stb=1, go to READ.
    - Writes always have priority over reads.
  - WRITE:
    - Hold outputs until wbm_ack_i or wbm_err_i.
    - Then deassert cyc/stb, pop the FIFO, go to IDLE. This gives one idle cycle between master transactions.
    - On wbm_err_i with wr_err_o==0: set wr_err_o and capture wr_err_adr_o. Later errors do not overwrite the captured address.
  - READ:
    - On wbm_ack_i or wbm_err_i: deassert cyc/stb, go to IDLE.
    - If the CPU drops wbs_cyc_i mid-READ, the master cycle still runs to ack/err and the response is discarded.
- Error flag:
  - wr_err_clr_i clears wr_err_o on the next edge.
  - If a set and a clear land in the same cycle, set wins.
- Cannot happen: a stalled CPU write while the FIFO is full does not block draining.
- idle_o is combinational from the FIFO count and FSM state.

Test Plan:
- Single write adr=0x9000_0000 dat=0xDEAD_BEEF sel=0xF, slave acks after 5 cycles:
  - wbs_ack_o is high exactly 1 cycle after the request.
  - wbm write appears the next cycle with identical adr/dat/sel and holds for 5 cycles.
  - idle_o returns to 1 after the ack.
- Five back-to-back writes with the slave stalled:
  - First 4 acked one per 2 cycles; the 5th is held without ack.
  - After the first wbm_ack_i, the 5th is acked.
  - All 5 reach wbm in order.
- Write 0x1234 to A, then immediately read A:
  - The read issues on wbm only after the write's wbm_ack_i.
  - Read data 0x1234 is returned with wbs_ack_o in the same cycle as wbm_ack_i.
- Two posted writes, the first receiving wbm_err_i at adr 0x2000_0004:
  - wr_err_o=1 and wr_err_adr_o=0x2000_0004.
  - The second write still completes.
  - Pulsing wr_err_clr_i clears the flag; the address is retained.
- Read with wbm_err_i response: wbs_err_o=1 for one cycle, wbs_ack_o=0, wr_err_o unaffected.
- Reset asserted while 3 writes are queued and the FSM is in WRITE:
  - All outputs go to 0 immediately and idle_o=1.
  - After release, no queued write ever appears on wbm.
